mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store alignment unit between the CPU memory stage and a word-wide single-port data memory.
- Handles byte, half and word accesses at any legal lane offset, with sign or zero extension on loads.
- Performs sub-word stores as read-modify-write, so memory needs no byte enables.
- Detects misaligned or illegal accesses before touching memory; parametrised in data and address width.

Parameters:
DATA_W, 32, memory word width in bits; power of 2, >= 16, multiple of 8
ADDR_W, 32, byte address width
LANE_W, $clog2(DATA_W/8), derived localparam; number of byte-offset address bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  CPU request valid
req_ready  out  1  unit idle, request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_size  in  2  0=word, 1=half, 2=byte, 3=reserved
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data (0 for stores/errors)
resp_misalign  out  1  qualifies resp_valid: access rejected
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word-aligned address (low LANE_W bits zero)
mem_wdata  out  DATA_W  write word
mem_rdata  in  DATA_W  read word, valid with mem_ack
mem_ack  in  1  memory completion; sampled only while mem_req=1

Behaviour:
- Byte lanes are little-endian: lane k = bits [8k+7:8k], k = addr[LANE_W-1:0]. A half occupies lanes k, k+1.
- Reset: state IDLE. req_ready=1. resp_valid, resp_misalign, mem_req, mem_we=0. resp_rdata, mem_addr, mem_wdata=0.
- Reset mid-operation: abandon immediately, with mem_req low the cycle after reset. An ack arriving later is ignored.
- States:
  - IDLE
  - RD: mem_req=1, mem_we=0
  - WR: mem_req=1, mem_we=1
  - DONE: resp_valid=1 for exactly one cycle, then back to IDLE
- req_ready=1 only in IDLE. On accept, latch all request fields. Inputs are ignored outside IDLE.
- Legality is checked in IDLE at accept:
  - size 3 is illegal.
  - Word requires addr[LANE_W-1:0]==0.
  - Half requires addr[0]==0.
  - Illegal access -> DONE with resp_misalign=1, resp_rdata=0, no memory request.
- Legal load -> RD. On ack, extract the lane(s) from mem_rdata, extend per req_unsigned, register into resp_rdata, then DONE.
- Legal word store -> WR with mem_wdata=req_wdata. On ack -> DONE.
- Legal half/byte store -> RD. On ack, merge req_wdata low bits into the captured word at the lane, preserving other lanes. Then WR with the merged word; on ack -> DONE.
- mem_addr = latched addr with low LANE_W bits cleared, held stable while mem_req=1.
- Minimum latency with ack in the first mem_req cycle, accept at cycle T:
  - load or word store: resp_valid at T+2
  - sub-word store: resp_valid at T+3
  - error: resp_valid at T+1
- Each extra ack wait cycle adds one cycle.
- mem_ack while mem_req=0 is ignored. No back-to-back accept: DONE always separates operations.
- Word load: req_unsigned has no effect.

Decomposition:
- Package mem_access_pkg:
  - size_e enum (SZ_WORD=0, SZ_HALF=1, SZ_BYTE=2)
  - state_e (IDLE, RD, WR, DONE)
- Sub-module lane_align (combinational, parametrised on DATA_W), used by the FSM top:
  - inputs: word, lane, size, unsigned, wdata
  - outputs: extended load value and merged store word

Test Plan (DATA_W=32, memory word at 0x100 = 0x8899AABB):
- lb 0x101 signed -> one read at 0x100, resp_rdata=0xFFFFFFAA; lbu same address -> 0x000000AA.
- lh 0x102 signed, mem_ack delayed 3 cycles -> resp_rdata=0xFFFF8899; resp_valid at accept+5; mem_addr stable 0x100 throughout.
- sh 0x102 wdata 0x1234BEEF -> read 0x100, then write 0xBEEFAABB; sb 0x100 wdata 0x55 -> 0x8899AA55; resp_valid at accept+3.
- sw 0x106, lh 0x101, size=3 -> resp_misalign=1 at accept+1; mem_req never asserted; resp_rdata=0.
- sw 0x104 wdata 0xDEADBEEF -> single write, mem_wdata=0xDEADBEEF, mem_addr=0x104, no read.
- reset asserted while in WR of an sb -> next cycle mem_req=0, req_ready=1, no resp_valid; a late mem_ack is ignored; the next request behaves normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the load/store alignment unit.
// Access sizes follow the CPU encoding; state_e drives the top-level FSM.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational; lanes are little-endian within the memory word.
module lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int LANE_W = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_store
);

    logic [LANE_W+2:0] w_sh;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_ins;

    assign w_sh      = {i_lane, 3'b000};
    assign w_shifted = i_word >> w_sh;

    always_comb begin
        w_mask = '1;
        o_load = i_word;
        unique case (i_size)
            SZ_BYTE: begin
                w_mask = DATA_W'(8'hFF);
                o_load = {{(DATA_W-8){~i_unsigned & w_shifted[7]}},
                          w_shifted[7:0]};
            end
            SZ_HALF: begin
                w_mask = DATA_W'(16'hFFFF);
                o_load = {{(DATA_W-16){~i_unsigned & w_shifted[15]}},
                          w_shifted[15:0]};
            end
            default: ;
        endcase
    end

    // Store data is right-justified; move it up to its lane and keep the rest.
    assign w_ins   = (i_wdata & w_mask) << w_sh;
    assign o_store = (i_word & ~(w_mask << w_sh)) | w_ins;

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store alignment unit in front of a word-wide memory.
// Sub-word stores are done as read-modify-write so memory needs no byte enables.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int LANE_W = $clog2(DATA_W/8);

    state_e r_state;
    state_e w_next;

    logic              r_we;
    logic              r_uns;
    logic              r_mis;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mwdata;

    logic              w_accept;
    logic              w_legal;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_store;

    assign w_accept = req_valid && (r_state == IDLE);

    always_comb begin
        w_legal = 1'b0;
        unique case (req_size)
            SZ_WORD: w_legal = (req_addr[LANE_W-1:0] == '0);
            SZ_HALF: w_legal = ~req_addr[0];
            SZ_BYTE: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    lane_align #(.DATA_W(DATA_W)) u_align (
        .i_word     (mem_rdata),
        .i_lane     (r_addr[LANE_W-1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_store    (w_store)
    );

    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_misalign = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    if (!w_legal)
                        w_next = DONE;
                    else if (req_we && req_size == SZ_WORD)
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_ack)
                    w_next = r_we ? WR : DONE;
            end
            WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack)
                    w_next = DONE;
            end
            DONE: begin
                resp_valid    = 1'b1;
                resp_misalign = r_mis;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_uns    <= 1'b0;
            r_mis    <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_mwdata <= '0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_uns    <= req_unsigned;
            r_mis    <= ~w_legal;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            r_mwdata <= req_wdata;
        end else if (r_state == RD && mem_ack) begin
            // A read phase either finishes a load or feeds the store merge.
            if (r_we)
                r_mwdata <= w_store;
            else
                r_rdata <= w_load;
        end
    end

    assign resp_rdata = r_rdata;
    assign mem_wdata  = r_mwdata;
    assign mem_addr   = {r_addr[ADDR_W-1:LANE_W], LANE_W'(0)};

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural memory
// and a byte-level reference model for loads, stores and legality.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [31:0] mem [0:63];
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    function automatic logic ref_legal(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'd3) return 1'b0;
        if (sz == 2'd0) return a[1:0] == 2'b00;
        if (sz == 2'd1) return a[0] == 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] sz,
                                             logic uns, logic [31:0] a);
        logic [7:0] by [4];
        logic [31:0] v;
        int k;
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        k = int'(a[1:0]);
        v = w;
        if (sz == 2'd2) begin
            v = 32'(by[k]);
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = 32'(by[k]) + 32'(by[k+1]) * 32'd256;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] w, logic [1:0] sz,
                                              logic [31:0] a, logic [31:0] wd);
        logic [7:0] by [4];
        int k;
        if (sz == 2'd0) return wd;
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        k = int'(a[1:0]);
        by[k] = wd[7:0];
        if (sz == 2'd1) by[k+1] = wd[15:8];
        return {by[3], by[2], by[1], by[0]};
    endfunction

    task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int dly,
                          output logic [31:0] rd, output logic mis,
                          output int lat, output int nrd, output int nwr,
                          output int nreq, output logic [31:0] waddr,
                          output logic [31:0] wdat, output logic stable,
                          output logic rdy_done, output logic to);
        int wt;
        bit done;
        rd = '0; mis = 1'b0; lat = 0; nrd = 0; nwr = 0; nreq = 0;
        waddr = '0; wdat = '0; stable = 1'b1; rdy_done = 1'b0; to = 1'b1;
        wt = 0; done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_we = 1'($urandom);
        for (int c = 1; c <= 40 && !done; c++) begin
            mem_ack = 1'b0;
            if (resp_valid) begin
                done = 1'b1; to = 1'b0; lat = c;
                rd = resp_rdata; mis = resp_misalign; rdy_done = req_ready;
            end else begin
                if (mem_req) begin
                    nreq++;
                    if (mem_addr !== {a[31:2], 2'b00}) stable = 1'b0;
                    if (wt == dly) begin
                        mem_ack = 1'b1; wt = 0;
                        if (mem_we) begin
                            nwr++; waddr = mem_addr; wdat = mem_wdata;
                            mem[mem_addr[7:2]] = mem_wdata;
                        end else begin
                            nrd++; mem_rdata = mem[mem_addr[7:2]];
                        end
                    end else begin
                        wt++;
                    end
                end
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_misalign !== 1'b0) begin errs++; $display("FAIL reset_misalign: got %b want 0", resp_misalign); end
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (resp_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        checks++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_load_byte;
        logic [31:0] rd, wa, wv; logic mis, st, rdy, to;
        int lat, nrd, nwr, nreq;
        mem[0] = 32'h8899AABB;
        run_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
        checks++; if (to || rd !== 32'hFFFFFFAA) begin errs++; $display("FAIL lb_signed: got %h want FFFFFFAA", rd); end
        checks++; if (lat != 2 || nrd != 1 || nwr != 0) begin errs++; $display("FAIL lb_timing: lat %0d rd %0d wr %0d want 2/1/0", lat, nrd, nwr); end
        checks++; if (rdy !== 1'b0) begin errs++; $display("FAIL lb_ready_in_done: got %b want 0", rdy); end
        run_op(1'b0, 2'd2, 1'b1, 32'h101, 32'h0, 0, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
        checks++; if (to || rd !== 32'h000000AA) begin errs++; $display("FAIL lbu: got %h want 000000AA", rd); end
    endtask

    task automatic test_load_half_delay;
        logic [31:0] rd, wa, wv; logic mis, st, rdy, to;
        int lat, nrd, nwr, nreq;
        mem[0] = 32'h8899AABB;
        run_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 3, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
        checks++; if (to || rd !== 32'hFFFF8899) begin errs++; $display("FAIL lh_signed: got %h want FFFF8899", rd); end
        checks++; if (lat != 5) begin errs++; $display("FAIL lh_latency: got %0d want 5", lat); end
        checks++; if (st !== 1'b1 || nreq != 4) begin errs++; $display("FAIL lh_addr_stable: stable %b req_cycles %0d want 1/4", st, nreq); end
        checks++; if (mis !== 1'b0) begin errs++; $display("FAIL lh_misalign: got %b want 0", mis); end
    endtask

    task automatic test_store_subword;
        logic [31:0] rd, wa, wv; logic mis, st, rdy, to;
        int lat, nrd, nwr, nreq;
        mem[0] = 32'h8899AABB;
        run_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234BEEF, 0, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
        checks++; if (to || wv !== 32'hBEEFAABB) begin errs++; $display("FAIL sh_merge: got %h want BEEFAABB", wv); end
        checks++; if (nrd != 1 || nwr != 1 || wa !== 32'h100) begin errs++; $display("FAIL sh_rmw: rd %0d wr %0d addr %h want 1/1/100", nrd, nwr, wa); end
        checks++; if (lat != 3 || rd !== 32'h0) begin errs++; $display("FAIL sh_resp: lat %0d rdata %h want 3/0", lat, rd); end
        mem[0] = 32'h8899AABB;
        run_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h00000055, 0, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
        checks++; if (to || wv !== 32'h8899AA55) begin errs++; $display("FAIL sb_merge: got %h want 8899AA55", wv); end
        checks++; if (lat != 3) begin errs++; $display("FAIL sb_latency: got %0d want 3", lat); end
    endtask

    task automatic test_errors;
        logic [31:0] rd, wa, wv; logic mis, st, rdy, to;
        int lat, nrd, nwr, nreq;
        logic        ewe [3] = '{1'b1, 1'b0, 1'b0};
        logic [1:0]  esz [3] = '{2'd0, 2'd1, 2'd3};
        logic [31:0] ead [3] = '{32'h106, 32'h101, 32'h100};
        for (int i = 0; i < 3; i++) begin
            run_op(ewe[i], esz[i], 1'b0, ead[i], 32'hCAFEF00D, 0, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
            checks++; if (to || mis !== 1'b1) begin errs++; $display("FAIL err%0d_misalign: got %b want 1", i, mis); end
            checks++; if (lat != 1) begin errs++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
            checks++; if (nreq != 0) begin errs++; $display("FAIL err%0d_no_mem: got %0d req cycles want 0", i, nreq); end
            checks++; if (rd !== 32'h0) begin errs++; $display("FAIL err%0d_rdata: got %h want 0", i, rd); end
        end
    endtask

    task automatic test_word_store;
        logic [31:0] rd, wa, wv; logic mis, st, rdy, to;
        int lat, nrd, nwr, nreq;
        run_op(1'b1, 2'd0, 1'b0, 32'h104, 32'hDEADBEEF, 0, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
        checks++; if (to || wv !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wdata: got %h want DEADBEEF", wv); end
        checks++; if (wa !== 32'h104) begin errs++; $display("FAIL sw_addr: got %h want 104", wa); end
        checks++; if (nrd != 0 || nwr != 1 || lat != 2) begin errs++; $display("FAIL sw_single_write: rd %0d wr %0d lat %0d want 0/1/2", nrd, nwr, lat); end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] rd, wa, wv; logic mis, st, rdy, to;
        int lat, nrd, nwr, nreq;
        bit bad;
        mem[0] = 32'h8899AABB;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h100; req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = mem[0];
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errs++; $display("FAIL mid_in_wr: req %b we %b want 1/1", mem_req, mem_we); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL mid_mem_req: got %b want 0", mem_req); end
        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL mid_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL mid_resp: got %b want 0", resp_valid); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad) begin errs++; $display("FAIL late_ack_ignored: got activity want none"); end
        run_op(1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 1, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
        checks++; if (to || rd !== 32'h000000BB || lat != 3) begin errs++; $display("FAIL after_reset_op: rdata %h lat %0d want 000000BB/3", rd, lat); end
    endtask

    task automatic test_random;
        logic [31:0] rd, wa, wv; logic mis, st, rdy, to;
        int lat, nrd, nwr, nreq;
        logic we, uns, leg; logic [1:0] sz; logic [31:0] a, wd, old;
        int dly, elat, enrd, enwr;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom_range(0, 3));
            a = 32'h100 + 32'($urandom_range(0, 255)); wd = $urandom;
            dly = $urandom_range(0, 2);
            old = mem[a[7:2]];
            leg = ref_legal(sz, a);
            if (!leg) begin elat = 1; enrd = 0; enwr = 0; end
            else if (!we) begin elat = 2 + dly; enrd = 1; enwr = 0; end
            else if (sz == 2'd0) begin elat = 2 + dly; enrd = 0; enwr = 1; end
            else begin elat = 3 + 2 * dly; enrd = 1; enwr = 1; end
            run_op(we, sz, uns, a, wd, dly, rd, mis, lat, nrd, nwr, nreq, wa, wv, st, rdy, to);
            checks++; if (to || mis !== !leg) begin errs++; $display("FAIL rnd%0d_misalign: got %b want %b", n, mis, !leg); end
            checks++; if (lat != elat || nrd != enrd || nwr != enwr) begin errs++; $display("FAIL rnd%0d_seq: lat %0d rd %0d wr %0d want %0d/%0d/%0d", n, lat, nrd, nwr, elat, enrd, enwr); end
            checks++; if (rd !== ((leg && !we) ? ref_load(old, sz, uns, a) : 32'h0)) begin errs++; $display("FAIL rnd%0d_rdata: got %h want %h", n, rd, (leg && !we) ? ref_load(old, sz, uns, a) : 32'h0); end
            checks++; if (leg && we && wv !== ref_store(old, sz, a, wd)) begin errs++; $display("FAIL rnd%0d_wdata: got %h want %h", n, wv, ref_store(old, sz, a, wd)); end
            checks++; if (st !== 1'b1) begin errs++; $display("FAIL rnd%0d_addr_stable: got %b want 1", n, st); end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_load_byte();
        test_load_half_delay();
        test_store_subword();
        test_errors();
        test_word_store();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
